// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants and a small window-decode helper used by the
// scan timer and its counters.
package vga_timing_pkg;

  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  localparam int unsigned H_TOTAL      = 1344;
  localparam int unsigned H_SYNC_START = 1048;
  localparam int unsigned H_SYNC_END   = 1184;

  localparam int unsigned V_SYNC_START = 771;
  localparam int unsigned V_SYNC_END   = 777;
  localparam int unsigned V_LAST_SHORT = 797;
  localparam int unsigned V_LAST_LONG  = 803;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_window(input logic [X_W-1:0] v,
                                     input logic [X_W-1:0] lo,
                                     input logic [X_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping raster axis counter: advances on carry_in, wraps to 0 once at or
// beyond the (run-time selectable) last value.
module vga_axis_counter #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // ">=" rather than "==" so a shrinking last value can never strand the count.
  assign tc = (count_q >= last);

  always_comb begin
    count_d = count_q;
    if (!rst_n) begin
      count_d = '0;
    end else if (carry_in) begin
      count_d = tc ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/vga_scan_timer.sv
// VGA scan timer: raster counters, sync/blank/retrace decode and a sticky
// hblank/vblank interrupt, all registered and aligned with x/y.
module vga_scan_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = 1024,
  parameter int unsigned H_NARROW  = 960,
  parameter int unsigned V_VISIBLE = 768
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cli,
  input  logic           enable_interrupt_on_hblank,
  input  logic           enable_interrupt_on_vblank,
  input  logic           narrow_960,
  input  logic           long_frame,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           hsync,
  output logic           vsync,
  output logic           blank,
  output logic           retrace,
  output logic           interrupt
);

  localparam logic [X_W-1:0] X_LAST       = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] HS_START     = X_W'(H_SYNC_START);
  localparam logic [X_W-1:0] HS_END       = X_W'(H_SYNC_END);
  localparam logic [X_W-1:0] VS_START     = X_W'(V_SYNC_START);
  localparam logic [X_W-1:0] VS_END       = X_W'(V_SYNC_END);
  localparam logic [X_W-1:0] X_WIDE       = X_W'(H_VISIBLE);
  localparam logic [X_W-1:0] X_NARROW     = X_W'(H_NARROW);
  localparam logic [Y_W-1:0] Y_VISIBLE    = Y_W'(V_VISIBLE);
  localparam logic [Y_W-1:0] Y_LAST_SHORT = Y_W'(V_LAST_SHORT);
  localparam logic [Y_W-1:0] Y_LAST_LONG  = Y_W'(V_LAST_LONG);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           h_tc;
  logic           v_tc_unused;
  logic [Y_W-1:0] v_last;
  logic [X_W-1:0] hblank_x;
  logic           hblank_ev;
  logic           vblank_ev;

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic blank_q, blank_d;
  logic retrace_q, retrace_d;
  logic interrupt_q, interrupt_d;

  assign v_last = long_frame ? Y_LAST_LONG : Y_LAST_SHORT;

  vga_axis_counter #(.WIDTH(X_W)) u_h_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .carry_in   (1'b1),
    .last       (X_LAST),
    .count      (x_q),
    .count_next (x_d),
    .tc         (h_tc)
  );

  vga_axis_counter #(.WIDTH(Y_W)) u_v_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .carry_in   (h_tc),
    .last       (v_last),
    .count      (y_q),
    .count_next (y_d),
    .tc         (v_tc_unused)
  );

  // Decode from the next-state counters so each registered flag lands in
  // the same cycle as the x/y it describes.
  always_comb begin
    hblank_x    = narrow_960 ? X_NARROW : X_WIDE;
    hblank_ev   = enable_interrupt_on_hblank && (y_d < Y_VISIBLE) && (x_d == hblank_x);
    vblank_ev   = enable_interrupt_on_vblank && (x_d == '0) && (y_d == Y_VISIBLE);
    hsync_d     = ~in_window(x_d, HS_START, HS_END);
    vsync_d     = ~in_window({1'b0, y_d}, VS_START, VS_END);
    blank_d     = (y_d >= Y_VISIBLE) || (x_d >= hblank_x);
    retrace_d   = (x_d == X_LAST);
    interrupt_d = hblank_ev || vblank_ev || (interrupt_q && !cli);
    if (!rst_n) begin
      hsync_d     = 1'b1;
      vsync_d     = 1'b1;
      blank_d     = 1'b0;
      retrace_d   = 1'b0;
      interrupt_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    hsync_q     <= hsync_d;
    vsync_q     <= vsync_d;
    blank_q     <= blank_d;
    retrace_q   <= retrace_d;
    interrupt_q <= interrupt_d;
  end

  assign x         = x_q;
  assign y         = y_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign blank     = blank_q;
  assign retrace   = retrace_q;
  assign interrupt = interrupt_q;

endmodule

// File: doc/vga_scan_timer.md
VGA_SCAN_TIMER -- requirements
Module: vga_scan_timer

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 1024, meaning visible clocks per scanline in wide mode.
REQ-002 SHALL have parameter H_NARROW, default 960, meaning visible clocks per scanline in narrow mode.
REQ-003 SHALL have parameter V_VISIBLE, default 768, meaning visible scanlines per frame.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port cli, input, 1, clears the pending interrupt.
REQ-007 SHALL have port enable_interrupt_on_hblank, input, 1, arms the per-line event.
REQ-008 SHALL have port enable_interrupt_on_vblank, input, 1, arms the per-frame event.
REQ-009 SHALL have port narrow_960, input, 1, 1 = 960-clock visible width.
REQ-010 SHALL have port long_frame, input, 1, 1 = 804 lines/frame, 0 = 798 lines/frame.
REQ-011 SHALL have port x, output, 11, horizontal counter.
REQ-012 SHALL have port y, output, 10, vertical counter.
REQ-013 SHALL have port hsync, output, 1, active-low.
REQ-014 SHALL have port vsync, output, 1, active-low.
REQ-015 SHALL have port blank, output, 1, 1 = outside the visible area.
REQ-016 SHALL have port retrace, output, 1, one-cycle end-of-line pulse.
REQ-017 SHALL have port interrupt, output, 1, sticky interrupt request.

Function
REQ-018 x SHALL count 0..1343 and wrap to 0; y SHALL increment when x wraps.
REQ-019 y SHALL wrap to 0 when x wraps and y >= last line, where last line = 803 if long_frame, else 797.
REQ-020 A long_frame change mid-frame SHALL take effect immediately; y is never left stuck above the last line.
REQ-021 hsync SHALL be 0 exactly for x in 1048..1183, independent of narrow_960.
REQ-022 vsync SHALL be 0 exactly for y in 771..776, in both frame lengths; the back porch absorbs the difference (21 or 27 lines).
REQ-023 blank SHALL be 1 when y >= 768, or when x >= 1024 (narrow_960=0), or when x >= 960 (narrow_960=1).
REQ-024 All outputs SHALL be registered and mutually aligned: hsync/vsync/blank/retrace in a cycle describe the x,y presented in that same cycle (decode from next-state counters).
REQ-025 retrace SHALL be 1 for exactly the cycle where x == 1343, on every line including vblank lines.
REQ-026 The hblank event SHALL occur in the cycle where blank rises while y < 768 (x == 1024, or x == 960 in narrow mode).
REQ-027 The vblank event SHALL occur in the cycle where x == 0 and y == 768.
REQ-028 interrupt SHALL be set on an event whose enable is 1 in that cycle.
REQ-029 interrupt SHALL remain set until a cycle with cli=1 and no concurrent enabled event.
REQ-030 On cli and an enabled event in the same cycle, interrupt SHALL remain 1, so no event is lost.
REQ-031 Toggling narrow_960 SHALL affect blank and the hblank event from the next cycle, with no effect on counters or sync.

Reset
REQ-032 With rst_n=0 at a clk edge: x=0, y=0, hsync=1, vsync=1, blank=0, retrace=0, interrupt=0.
REQ-033 Reset asserted mid-line or mid-vsync SHALL restart the frame at (0,0) on the next edge; a pending interrupt is discarded.

Structure
REQ-034 Shared package vga_timing_pkg SHALL hold the horizontal constants H_TOTAL=1344, H_SYNC_START=1048, H_SYNC_END=1184.
REQ-035 vga_timing_pkg SHALL hold the vertical constants V_SYNC_START=771, V_SYNC_END=777, V_LAST_SHORT=797, V_LAST_LONG=803.
REQ-036 One sub-module, vga_axis_counter (wrapping counter with a terminal-count output and a carry-in enable), SHALL be instantiated twice: once for h and once for v.

Verification
REQ-037 Reset, then run 1344*798 cycles with long_frame=0 -> y returns to 0 exactly at cycle 1344*798; vsync is low for 6*1344 cycles per frame.
REQ-038 long_frame=1 -> frame period 1344*804 cycles; clearing long_frame while y=800 -> y wraps to 0 at the end of line 800.
REQ-039 narrow_960=1, enable_interrupt_on_hblank=1, y=10 -> interrupt rises in the cycle x==960, blank rises in the same cycle, hsync falls at x==1048.
REQ-040 enable_interrupt_on_vblank=1 -> interrupt rises at (x=0, y=768); cli pulse -> interrupt 0 next cycle; cli coincident with the event -> interrupt stays 1.
REQ-041 retrace -> exactly one pulse per 1344 cycles, at x==1343, including during lines 768..797.
REQ-042 rst_n=0 at x=1100, y=773 -> next cycle x=0, y=0, hsync=1, vsync=1, interrupt=0.
